fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, PC value loaded on reset.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PCWrite  in  1  0 = freeze PC.
- IF_ID_Flush  in  1  1 = load bubble into IF/ID and redirect PC.
- IF_ID_Hold  in  1  1 = IF/ID retains contents.
- PCSrc  in  2  redirect select: 00 none, 01 branch, 10 jump, 11 jr.
- branch_target  in  32  beq/bne target.
- jump_target  in  32  j/jal target.
- jr_target  in  32  jr register target.
- imem_addr  out  32  fetch address, always equal to PC.
- imem_req  out  1  fetch request.
- imem_ready  in  1  imem_rdata valid for current imem_addr.
- imem_rdata  in  32  fetched instruction.
- IF_ID_Instr  out  32  registered instruction to decode.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = IF_ID_Instr is a real instruction.

Function
REQ-003 Three states: S_BOOT, S_FETCH, S_PEND; one-entry pending buffer pend_instr (32 bits).
REQ-004 imem_req SHALL be 1 only in S_FETCH; imem_ready SHALL be ignored in S_BOOT and S_PEND.
REQ-005 S_BOOT lasts exactly one cycle after rst deasserts: IF/ID loaded with bubble, PC unchanged, next state S_FETCH.
REQ-006 Bubble means IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
REQ-007 Per-cycle priority outside reset: Flush > Stall (IF_ID_Hold=1 or PCWrite=0) > Advance.
REQ-008 Flush: IF/ID loaded with bubble; PC loaded per PCSrc (01 branch_target, 10 jump_target, 11 jr_target, 00 PC unchanged); pend discarded; any same-cycle imem_ready response discarded; next state S_FETCH.
REQ-009 Stall: IF/ID and PC unchanged; if S_FETCH and imem_ready, pend_instr loaded from imem_rdata and next state S_PEND; otherwise state unchanged.
REQ-010 Advance from S_PEND: IF/ID loaded with pend_instr, PC+4, Valid=1; PC incremented by 4; next state S_FETCH.
REQ-011 Advance from S_FETCH with imem_ready=1: IF/ID loaded with imem_rdata, PC+4, Valid=1; PC incremented by 4; state stays S_FETCH.
REQ-012 Advance from S_FETCH with imem_ready=0: IF/ID loaded with bubble; PC unchanged.
REQ-013 PCSrc SHALL be used only during Flush; in all other cases PC increments sequentially.
REQ-014 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-015 PC[1:0] SHALL always be 00; bits [1:0] of every target are ignored.
REQ-016 Single-cycle fetch latency (imem_ready same cycle as imem_req) SHALL sustain one instruction per cycle with no bubbles.
REQ-017 Memory protocol is level-based: imem_addr may change while a fetch is outstanding, and the response always applies to the current imem_addr.

Reset
REQ-018 While rst=1: PC=RESET_PC, IF/ID=bubble, pend cleared, state S_BOOT, imem_req=0; all other inputs ignored.
REQ-019 rst asserted mid-fetch or while in S_PEND SHALL discard the outstanding or pending instruction.
REQ-020 The first imem_req SHALL occur in the second cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-021 Reset release, imem_ready tied 1, rdata=addr -> IF_ID_Instr 0x00400000, 0x00400004, ... on consecutive cycles with Valid=1; PCPlus4 = instr+4.
REQ-022 Hold=1 and PCWrite=0 for 2 cycles, ready=1 -> IF/ID frozen; pend captures the first response, imem_req=0 in the second cycle; after release the pending instruction enters IF/ID and the next fetch is PC+4.
REQ-023 Flush with PCSrc=01, branch_target=0x00400100, simultaneous ready=1 -> bubble in IF/ID; next imem_addr=0x00400100; the same-cycle response is not used.
REQ-024 imem_ready held 0 for 3 cycles in S_FETCH -> 3 bubbles, PC constant, imem_req stays 1.
REQ-025 PC=0xFFFFFFFC, ready=1 -> next PC=0x00000000; IF_ID_PCPlus4=0x00000000.
REQ-026 rst asserted while in S_PEND -> next cycle IF/ID is a bubble, PC=RESET_PC, the pending instruction never appears in IF/ID.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a level-based instruction memory
// request and fills the IF/ID pipeline register, with a one-entry pending buffer.
//
// state   | meaning
// S_BOOT  | first cycle after reset release; IF/ID bubble, no fetch
// S_FETCH | imem_req asserted for PC, response accepted when imem_ready
// S_PEND  | response captured during a stall, waiting to enter IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Flush,
  input  logic        IF_ID_Hold,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_PEND} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend_instr, pend_nx;
  logic [31:0] instr_nx, pcp4_nx;
  logic        valid_nx;
  logic [31:0] pc_plus4;
  logic        stall;

  assign pc_plus4  = pc + 32'd4;
  assign stall     = IF_ID_Hold | ~PCWrite;
  assign imem_addr = pc;
  assign imem_req  = (state == S_FETCH) & ~rst;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pend_nx  = pend_instr;
    instr_nx = IF_ID_Instr;
    pcp4_nx  = IF_ID_PCPlus4;
    valid_nx = IF_ID_Valid;
    if (state == S_BOOT) begin
      instr_nx = '0;
      pcp4_nx  = '0;
      valid_nx = 1'b0;
      state_nx = S_FETCH;
    end else if (IF_ID_Flush) begin
      instr_nx = '0;
      pcp4_nx  = '0;
      valid_nx = 1'b0;
      pend_nx  = '0;
      state_nx = S_FETCH;
      // target low bits are dropped so the PC stays word aligned
      unique case (PCSrc)
        2'b01:   pc_nx = {branch_target[31:2], 2'b00};
        2'b10:   pc_nx = {jump_target[31:2], 2'b00};
        2'b11:   pc_nx = {jr_target[31:2], 2'b00};
        default: pc_nx = pc;
      endcase
    end else if (stall) begin
      if (state == S_FETCH && imem_ready) begin
        pend_nx  = imem_rdata;
        state_nx = S_PEND;
      end
    end else if (state == S_PEND) begin
      instr_nx = pend_instr;
      pcp4_nx  = pc_plus4;
      valid_nx = 1'b1;
      pc_nx    = pc_plus4;
      state_nx = S_FETCH;
    end else if (imem_ready) begin
      instr_nx = imem_rdata;
      pcp4_nx  = pc_plus4;
      valid_nx = 1'b1;
      pc_nx    = pc_plus4;
    end else begin
      instr_nx = '0;
      pcp4_nx  = '0;
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_BOOT;
      pc            <= {RESET_PC[31:2], 2'b00};
      pend_instr    <= '0;
      IF_ID_Instr   <= '0;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      pend_instr    <= pend_nx;
      IF_ID_Instr   <= instr_nx;
      IF_ID_PCPlus4 <= pcp4_nx;
      IF_ID_Valid   <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus steps a behavioural pipeline model and
// queues the expected post-edge outputs; a monitor pops and compares every cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, PCWrite, IF_ID_Flush, IF_ID_Hold, imem_ready;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target, jump_target, jr_target, imem_rdata;
  logic [31:0] imem_addr, IF_ID_Instr, IF_ID_PCPlus4;
  logic        imem_req, IF_ID_Valid;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Flush(IF_ID_Flush),
    .IF_ID_Hold(IF_ID_Hold), .PCSrc(PCSrc), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] addr;
    logic        req;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 0;

  // reference model: PC, instructions waiting to enter IF/ID, and a boot marker
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_held[$];
  bit          m_booting = 1;
  logic [31:0] m_instr = 0, m_pcp4 = 0;
  logic        m_valid = 0;
  logic [31:0] key = 0;

  task automatic do_cycle(input bit r, input bit pw, input bit fl, input bit hd,
                          input logic [1:0] src, input logic [31:0] bt,
                          input logic [31:0] jt, input logic [31:0] jrt, input bit rdy);
    logic [31:0] rd;
    exp_t e;
    rd = m_pc ^ key;
    rst = r; PCWrite = pw; IF_ID_Flush = fl; IF_ID_Hold = hd; PCSrc = src;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    imem_ready = rdy; imem_rdata = rd;
    if (r) begin
      m_pc = RESET_PC; m_held.delete(); m_booting = 1;
      m_instr = 0; m_pcp4 = 0; m_valid = 0;
    end else if (m_booting) begin
      m_booting = 0; m_instr = 0; m_pcp4 = 0; m_valid = 0;
    end else if (fl) begin
      m_instr = 0; m_pcp4 = 0; m_valid = 0; m_held.delete();
      if (src == 2'd1) m_pc = bt & ~32'd3;
      else if (src == 2'd2) m_pc = jt & ~32'd3;
      else if (src == 2'd3) m_pc = jrt & ~32'd3;
    end else if (hd || !pw) begin
      if (m_held.size() == 0 && rdy) m_held.push_back(rd);
    end else if (m_held.size() > 0) begin
      m_instr = m_held.pop_front(); m_pcp4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end else if (rdy) begin
      m_instr = rd; m_pcp4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end else begin
      m_instr = 0; m_pcp4 = 0; m_valid = 0;
    end
    e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid; e.addr = m_pc;
    e.req = !r && !m_booting && (m_held.size() == 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic normal(input bit rdy);
    do_cycle(0, 1, 0, 0, 2'd0, 0, 0, 0, rdy);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("if_id_instr", IF_ID_Instr, e.instr);
        check("if_id_pcplus4", IF_ID_PCPlus4, e.pcp4);
        check("if_id_valid", {31'd0, IF_ID_Valid}, {31'd0, e.valid});
        check("imem_addr", imem_addr, e.addr);
        check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      end
    end
  end

  initial begin : stimulus
    do_cycle(1, 1, 0, 0, 2'd0, 0, 0, 0, 1);
    do_cycle(1, 0, 1, 1, 2'd3, 32'h1234_5678, 0, 32'h9999_0000, 1);
    for (int i = 0; i < 8; i++) normal(1);
    do_cycle(0, 0, 0, 1, 2'd1, 32'h0000_0040, 0, 0, 1);
    do_cycle(0, 0, 0, 1, 2'd1, 32'h0000_0040, 0, 0, 1);
    for (int i = 0; i < 3; i++) normal(1);
    do_cycle(0, 1, 1, 0, 2'd1, 32'h0040_0100, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) normal(1);
    for (int i = 0; i < 3; i++) normal(0);
    for (int i = 0; i < 2; i++) normal(1);
    do_cycle(0, 1, 1, 0, 2'd3, 0, 0, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 3; i++) normal(1);
    do_cycle(0, 1, 0, 1, 2'd0, 0, 0, 0, 1);
    do_cycle(1, 1, 0, 0, 2'd0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) normal(1);
    key = 32'hA5C3_0F1E;
    for (int i = 0; i < 3000; i++) begin
      bit r, pw, fl, hd, rdy;
      if (i % 500 == 250) key = $urandom;
      r   = ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 8);
      hd  = ($urandom_range(0, 99) < 15);
      pw  = ($urandom_range(0, 99) >= 15);
      rdy = ($urandom_range(0, 99) < 70);
      do_cycle(r, pw, fl, hd, 2'($urandom_range(0, 3)), $urandom, $urandom,
               ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : $urandom, rdy);
    end
    repeat (3) @(negedge clk);
    stim_done = 1;
  end

  initial begin : finisher
    fork
      wait (stim_done);
      #200000;
    join_any
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: stim_done=%0d pending=%0d expected 1 and 0", stim_done, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
